// File: rtl/mult_iter_pkg.sv
// Shared types and elaboration helpers for the parametrised iterative multiplier.
package mult_iter_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    // Partial products needed to cover a WIDTH x WIDTH product.
    function automatic int unsigned num_pp(int unsigned width, int unsigned a_chunk,
                                           int unsigned b_chunk);
        return (width / a_chunk) * (width / b_chunk);
    endfunction

    // Counter width for stepping over width/chunk chunks; never narrower than one bit.
    function automatic int unsigned cnt_w(int unsigned width, int unsigned chunk);
        int unsigned n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_iter_param_if.sv
// Request/result bundle between the datapath client and the iterative multiplier.
interface mult_iter_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic               is_signed;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, is_signed, a, b, input busy, done, product);
    modport slave  (input start, is_signed, a, b, output busy, done, product);
endinterface

// File: rtl/mult_iter_ctrl.sv
// Sequencer for the iterative multiplier: IDLE/CALC/FIX FSM plus the a/b chunk counters.
module mult_iter_ctrl
    import mult_iter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned A_CHUNK = 16,
    parameter int unsigned B_CHUNK = 8,
    localparam int unsigned IW     = cnt_w(WIDTH, A_CHUNK),
    localparam int unsigned JW     = cnt_w(WIDTH, B_CHUNK)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [IW-1:0] a_sel,
    output logic [JW-1:0] b_sel,
    output logic          upd_prod,
    output logic          clr_prod,
    output logic          neg_fix,
    output logic          busy,
    output logic          done
);
    localparam int unsigned IN = WIDTH / A_CHUNK;
    localparam int unsigned JN = WIDTH / B_CHUNK;

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic          done_q, done_d;

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        done_d   = 1'b0;
        upd_prod = 1'b0;
        clr_prod = 1'b0;
        neg_fix  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr_prod = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                upd_prod = 1'b1;
                // b-chunk index is the inner loop
                if (j_q == JW'(JN - 1)) begin
                    j_d = '0;
                    if (i_q == IW'(IN - 1)) begin
                        i_d     = '0;
                        state_d = FIX;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            FIX: begin
                neg_fix = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            done_q  <= done_d;
        end
    end

    assign a_sel = i_q;
    assign b_sel = j_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: rtl/mult_iter_param.sv
// Parametrised iterative multiplier: magnitude capture, chunked shift-accumulate, sign fix-up.
module mult_iter_param
    import mult_iter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned A_CHUNK = 16,
    parameter int unsigned B_CHUNK = 8
) (
    input  logic              clk,
    input  logic              reset,
    mult_iter_param_if.slave  bus
);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned PPW = A_CHUNK + B_CHUNK;
    localparam int unsigned IW  = cnt_w(WIDTH, A_CHUNK);
    localparam int unsigned JW  = cnt_w(WIDTH, B_CHUNK);

    if (A_CHUNK == 0 || B_CHUNK == 0 || A_CHUNK > WIDTH || B_CHUNK > WIDTH ||
        (WIDTH % A_CHUNK) != 0 || (WIDTH % B_CHUNK) != 0) begin : g_bad_params
        $error("mult_iter_param: chunk sizes must be non-zero, <= WIDTH and divide WIDTH");
    end

    logic [IW-1:0]      a_sel;
    logic [JW-1:0]      b_sel;
    logic               upd_prod, clr_prod, neg_fix;
    logic [WIDTH-1:0]   a_mag_q, b_mag_q, a_mag, b_mag;
    logic               neg_q;
    logic [PW-1:0]      prod_q, prod_d, pp_shift;
    logic [A_CHUNK-1:0] a_chunk;
    logic [B_CHUNK-1:0] b_chunk;
    logic [PPW-1:0]     pp;
    logic [31:0]        shamt;

    mult_iter_ctrl #(
        .WIDTH   (WIDTH),
        .A_CHUNK (A_CHUNK),
        .B_CHUNK (B_CHUNK)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (bus.start),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .upd_prod (upd_prod),
        .clr_prod (clr_prod),
        .neg_fix  (neg_fix),
        .busy     (bus.busy),
        .done     (bus.done)
    );

    // The most-negative value negates to itself, which is exactly its unsigned magnitude.
    assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign a_chunk  = a_mag_q[32'(a_sel) * A_CHUNK +: A_CHUNK];
    assign b_chunk  = b_mag_q[32'(b_sel) * B_CHUNK +: B_CHUNK];
    assign pp       = PPW'(a_chunk) * PPW'(b_chunk);
    assign shamt    = 32'(a_sel) * A_CHUNK + 32'(b_sel) * B_CHUNK;
    assign pp_shift = PW'(pp) << shamt;

    always_comb begin
        prod_d = prod_q;
        if (clr_prod) begin
            prod_d = '0;
        end else if (upd_prod) begin
            prod_d = prod_q + pp_shift;
        end else if (neg_fix && neg_q) begin
            prod_d = -prod_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            prod_q <= prod_d;
            if (clr_prod) begin
                a_mag_q <= a_mag;
                b_mag_q <= b_mag;
                neg_q   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end
        end
    end

    assign bus.product = prod_q;

endmodule

// File: tb/tb_mult_iter_param.sv
// Self-checking bench: directed corners on the default build plus random sweeps on two other builds.
module tb_mult_iter_param;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mult_iter_param_if #(.WIDTH(32)) bus0 ();
    mult_iter_param_if #(.WIDTH(16)) bus1 ();
    mult_iter_param_if #(.WIDTH(8))  bus2 ();

    mult_iter_param #(.WIDTH(32), .A_CHUNK(16), .B_CHUNK(8)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );
    mult_iter_param #(.WIDTH(16), .A_CHUNK(4), .B_CHUNK(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );
    mult_iter_param #(.WIDTH(8), .A_CHUNK(8), .B_CHUNK(8)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact product of two w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] ref_mul(input int unsigned w, input logic sgn,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] opm, pm, ae, be;
        opm = (64'd1 << w) - 64'd1;
        pm  = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        ae  = a & opm;
        be  = b & opm;
        if (sgn && ae[w-1]) ae = ae | ~opm;
        if (sgn && be[w-1]) be = be | ~opm;
        return (ae * be) & pm;
    endfunction

    task automatic drive(input int d, input logic st, input logic sgn,
                         input logic [63:0] a, input logic [63:0] b);
        case (d)
            0: begin bus0.start = st; bus0.is_signed = sgn; bus0.a = a[31:0]; bus0.b = b[31:0]; end
            1: begin bus1.start = st; bus1.is_signed = sgn; bus1.a = a[15:0]; bus1.b = b[15:0]; end
            default: begin
                bus2.start = st; bus2.is_signed = sgn; bus2.a = a[7:0]; bus2.b = b[7:0];
            end
        endcase
    endtask

    task automatic sample(input int d, output logic bs, output logic dn, output logic [63:0] p);
        case (d)
            0: begin bs = bus0.busy; dn = bus0.done; p = bus0.product; end
            1: begin bs = bus1.busy; dn = bus1.done; p = {32'b0, bus1.product}; end
            default: begin bs = bus2.busy; dn = bus2.done; p = {48'b0, bus2.product}; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge inside the done cycle (or after the budget).
    task automatic run_op(input int d, input logic sgn, input logic [63:0] a,
                          input logic [63:0] b, input bit interfere,
                          output logic [63:0] prod, output logic [63:0] first_prod,
                          output int busy_cnt, output bit timed_out);
        logic        bs, dn;
        logic [63:0] p;
        drive(d, 1'b1, sgn, a, b);
        @(negedge clk);
        drive(d, 1'b0, sgn, a, b);
        timed_out  = 1'b1;
        busy_cnt   = 0;
        prod       = '0;
        first_prod = '1;
        for (int k = 0; k < 200; k++) begin
            sample(d, bs, dn, p);
            if (k == 0) first_prod = p;
            if (dn) begin
                prod      = p;
                timed_out = 1'b0;
                break;
            end
            if (bs) busy_cnt++;
            if (interfere && k == 2) drive(d, 1'b1, ~sgn, ~a, b + 64'd11);
            if (interfere && k == 3) drive(d, 1'b0, ~sgn, ~a, b + 64'd11);
            @(negedge clk);
        end
        if (timed_out) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic        bs, dn;
        logic [63:0] p, fp, ra, rb;
        int          bc;
        bit          to;
        logic        sgn;
        int unsigned w;
        int          exp_busy;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sample(d, bs, dn, p);
            check($sformatf("reset_busy_%0d", d), {63'b0, bs}, 64'd0);
            check($sformatf("reset_done_%0d", d), {63'b0, dn}, 64'd0);
            check($sformatf("reset_prod_%0d", d), p, 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        run_op(0, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, p, fp, bc, to);
        check("umax_prod", p, 64'hFFFF_FFFE_0000_0001);
        check("umax_busy_cycles", 64'(bc), 64'd9);
        @(negedge clk);
        sample(0, bs, dn, p);
        check("done_single_cycle", {63'b0, dn}, 64'd0);
        check("prod_holds", p, 64'hFFFF_FFFE_0000_0001);

        run_op(0, 1'b1, 64'hFFFF_FFFD, 64'd7, 1'b0, p, fp, bc, to);
        check("signed_m3x7", p, 64'hFFFF_FFFF_FFFF_FFEB);
        check("start_clears_prod", fp, 64'd0);
        @(negedge clk);
        run_op(0, 1'b0, 64'hFFFF_FFFD, 64'd7, 1'b0, p, fp, bc, to);
        check("unsigned_fffffffdx7", p, 64'h0000_0006_FFFF_FFEB);
        @(negedge clk);
        run_op(0, 1'b1, 64'h8000_0000, 64'h8000_0000, 1'b0, p, fp, bc, to);
        check("minneg_sq", p, 64'h4000_0000_0000_0000);
        @(negedge clk);
        run_op(0, 1'b1, 64'h8000_0000, 64'd1, 1'b0, p, fp, bc, to);
        check("minneg_x1", p, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        run_op(0, 1'b1, 64'd0, 64'h8000_0000, 1'b0, p, fp, bc, to);
        check("zero_x_minneg", p, 64'd0);
        @(negedge clk);

        // Start pulse and operand churn while busy must not disturb the running operation.
        run_op(0, 1'b0, 64'd12345, 64'd678, 1'b1, p, fp, bc, to);
        check("ignored_start_prod", p, 64'd8369910);
        check("ignored_start_busy", 64'(bc), 64'd9);
        // Back-to-back: start issued in the done cycle.
        run_op(0, 1'b0, 64'd3, 64'd5, 1'b0, p, fp, bc, to);
        check("b2b_prod", p, 64'd15);
        check("b2b_busy", 64'(bc), 64'd9);
        check("b2b_clears_prod", fp, 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        drive(0, 1'b1, 1'b0, 64'h1234_5678, 64'h9ABC_DEF0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 64'h1234_5678, 64'h9ABC_DEF0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        sample(0, bs, dn, p);
        check("async_rst_busy", {63'b0, bs}, 64'd0);
        check("async_rst_done", {63'b0, dn}, 64'd0);
        check("async_rst_prod", p, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(0, 1'b0, 64'd6, 64'd7, 1'b0, p, fp, bc, to);
        check("after_rst_6x7", p, 64'd42);
        @(negedge clk);

        // Random sweeps on the narrow builds.
        for (int d = 1; d < 3; d++) begin
            w        = (d == 1) ? 16 : 8;
            exp_busy = (d == 1) ? 17 : 2;
            for (int k = 0; k < 1000; k++) begin
                ra  = {$urandom, $urandom};
                rb  = {$urandom, $urandom};
                sgn = 1'($urandom_range(0, 1));
                if (k % 97 == 0) ra = 64'd1 << (w - 1);
                if (k % 89 == 0) rb = '1;
                run_op(d, sgn, ra, rb, 1'b0, p, fp, bc, to);
                check($sformatf("sweep%0d_prod a=%h b=%h s=%0d", d, ra, rb, sgn), p,
                      ref_mul(w, sgn, ra, rb));
                if (k % 100 == 0) check($sformatf("sweep%0d_busy", d), 64'(bc), 64'(exp_busy));
                if (to) break;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
